// File: rtl/sevenseg_scan.sv
// Scanned driver for a 3-digit common-anode seven-segment display.
// A double-buffered 12-bit hex value is swapped in only at frame boundaries so digits never tear.
module sevenseg_scan #(
  parameter int TICKS_PER_DIGIT = 50000,
  parameter int BLANK_TICKS     = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [11:0] wr_value,
  input  logic [2:0]  wr_dp,
  input  logic [2:0]  wr_blank,
  input  logic        lz_en,
  output logic [7:0]  ss,
  output logic [2:0]  ssen,
  output logic        frame_done,
  output logic        pending
);

  localparam int CW = $clog2(TICKS_PER_DIGIT);
  localparam logic [CW-1:0] CNT_LAST  = CW'(TICKS_PER_DIGIT - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_TICKS);

  function automatic logic [6:0] hex_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  logic [CW-1:0] cnt_reg, cnt_next;
  logic [1:0]    digit_reg, digit_next;
  logic [11:0]   act_value_reg, act_value_next;
  logic [2:0]    act_dp_reg, act_dp_next;
  logic [2:0]    act_blank_reg, act_blank_next;
  logic [11:0]   pend_value_reg, pend_value_next;
  logic [2:0]    pend_dp_reg, pend_dp_next;
  logic [2:0]    pend_blank_reg, pend_blank_next;
  logic          pending_reg, pending_next;
  logic [7:0]    ss_reg, ss_next;
  logic [2:0]    ssen_reg, ssen_next;
  logic          frame_done_reg;
  logic          boundary;

  always_comb begin
    boundary        = (digit_reg == 2'd2) && (cnt_reg == CNT_LAST);
    cnt_next        = cnt_reg + CW'(1);
    digit_next      = digit_reg;
    act_value_next  = act_value_reg;
    act_dp_next     = act_dp_reg;
    act_blank_next  = act_blank_reg;
    pend_value_next = pend_value_reg;
    pend_dp_next    = pend_dp_reg;
    pend_blank_next = pend_blank_reg;
    pending_next    = pending_reg;
    if (cnt_reg == CNT_LAST) begin
      cnt_next   = '0;
      digit_next = (digit_reg == 2'd2) ? 2'd0 : digit_reg + 2'd1;
    end
    if (wr_en) begin
      pend_value_next = wr_value;
      pend_dp_next    = wr_dp;
      pend_blank_next = wr_blank;
      pending_next    = 1'b1;
    end
    // A write landing on the boundary edge bypasses the pending buffer.
    if (boundary) begin
      if (wr_en) begin
        act_value_next = wr_value;
        act_dp_next    = wr_dp;
        act_blank_next = wr_blank;
        pending_next   = 1'b0;
      end else if (pending_reg) begin
        act_value_next = pend_value_reg;
        act_dp_next    = pend_dp_reg;
        act_blank_next = pend_blank_reg;
        pending_next   = 1'b0;
      end
    end
  end

  // Pin values are computed from next-state so the registered pins line up with cnt/digit.
  logic [6:0] seg_dig [3];
  logic [2:0] dark_dig;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_digit
      assign seg_dig[gi] = hex_seg(act_value_next[gi*4 +: 4]);
    end
  endgenerate

  assign dark_dig[0] = act_blank_next[0];
  assign dark_dig[1] = act_blank_next[1] | (lz_en & (act_value_next[11:4] == 8'h00));
  assign dark_dig[2] = act_blank_next[2] | (lz_en & (act_value_next[11:8] == 4'h0));

  logic [6:0] sel_seg;
  logic       sel_dp;
  logic       sel_dark;
  logic [2:0] sel_en;

  always_comb begin
    case (digit_next)
      2'd0: begin
        sel_seg  = seg_dig[0];
        sel_dp   = act_dp_next[0];
        sel_dark = dark_dig[0];
        sel_en   = 3'b110;
      end
      2'd1: begin
        sel_seg  = seg_dig[1];
        sel_dp   = act_dp_next[1];
        sel_dark = dark_dig[1];
        sel_en   = 3'b101;
      end
      default: begin
        sel_seg  = seg_dig[2];
        sel_dp   = act_dp_next[2];
        sel_dark = dark_dig[2];
        sel_en   = 3'b011;
      end
    endcase
    ss_next   = 8'hFF;
    ssen_next = 3'b111;
    if ((cnt_next >= CNT_BLANK) && !sel_dark) begin
      ss_next   = {~sel_dp, ~sel_seg};
      ssen_next = sel_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg        <= '0;
      digit_reg      <= 2'd0;
      act_value_reg  <= 12'h000;
      act_dp_reg     <= 3'b000;
      act_blank_reg  <= 3'b111;
      pend_value_reg <= 12'h000;
      pend_dp_reg    <= 3'b000;
      pend_blank_reg <= 3'b111;
      pending_reg    <= 1'b0;
      ss_reg         <= 8'hFF;
      ssen_reg       <= 3'b111;
      frame_done_reg <= 1'b0;
    end else begin
      cnt_reg        <= cnt_next;
      digit_reg      <= digit_next;
      act_value_reg  <= act_value_next;
      act_dp_reg     <= act_dp_next;
      act_blank_reg  <= act_blank_next;
      pend_value_reg <= pend_value_next;
      pend_dp_reg    <= pend_dp_next;
      pend_blank_reg <= pend_blank_next;
      pending_reg    <= pending_next;
      ss_reg         <= ss_next;
      ssen_reg       <= ssen_next;
      frame_done_reg <= boundary;
    end
  end

  assign ss         = ss_reg;
  assign ssen       = ssen_reg;
  assign frame_done = frame_done_reg;
  assign pending    = pending_reg;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Scoreboard bench for sevenseg_scan: stimulus queues per-frame expected digit patterns,
// a negedge monitor tracks frame position from frame_done and checks every cycle of a queued frame.
module tb_sevenseg_scan;

  localparam int TPD   = 8;
  localparam int BLK   = 2;
  localparam int FRAME = 3 * TPD;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [11:0] wr_value;
  logic [2:0]  wr_dp;
  logic [2:0]  wr_blank;
  logic        lz_en;
  logic [7:0]  ss;
  logic [2:0]  ssen;
  logic        frame_done;
  logic        pending;

  sevenseg_scan #(
    .TICKS_PER_DIGIT(TPD),
    .BLANK_TICKS    (BLK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_value  (wr_value),
    .wr_dp     (wr_dp),
    .wr_blank  (wr_blank),
    .lz_en     (lz_en),
    .ss        (ss),
    .ssen      (ssen),
    .frame_done(frame_done),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  // Expected pin pattern of one frame; 8'hFF marks a digit that stays dark all slot.
  typedef struct {
    int         frame;
    logic [7:0] s0;
    logic [7:0] s1;
    logic [7:0] s2;
  } frame_exp_t;

  frame_exp_t exp_q[$];
  frame_exp_t cur;
  bit         checking = 1'b0;
  int         pos      = -1;
  int         frame_no = 0;
  int         checks   = 0;
  int         failures = 0;

  task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    int         d;
    int         c;
    logic [7:0] e_seg;
    logic [7:0] e_ss;
    logic [2:0] e_en;
    if (rst) begin
      pos      = -1;
      checking = 1'b0;
    end else begin
      if (frame_done) begin
        if (pos >= 0)
          check8("frame_period", 8'(pos + 1), 8'(FRAME));
        pos = 0;
        frame_no++;
        while (exp_q.size() > 0 && exp_q[0].frame < frame_no) begin
          checks++;
          failures++;
          $display("FAIL frame_missed actual=%0d required=%0d", frame_no, exp_q[0].frame);
          void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].frame == frame_no) begin
          cur      = exp_q.pop_front();
          checking = 1'b1;
          $display("frame %0d checking ss0=%h ss1=%h ss2=%h", frame_no, cur.s0, cur.s1, cur.s2);
        end else begin
          checking = 1'b0;
        end
      end else if (pos >= 0) begin
        pos++;
        if (pos >= FRAME) begin
          checks++;
          failures++;
          $display("FAIL frame_done_missing actual=none required=pulse_at_%0d", FRAME);
          pos      = -1;
          checking = 1'b0;
        end
      end
      if (checking && pos >= 0) begin
        d     = pos / TPD;
        c     = pos % TPD;
        e_seg = (d == 0) ? cur.s0 : (d == 1) ? cur.s1 : cur.s2;
        if (c < BLK || e_seg == 8'hFF) begin
          e_ss = 8'hFF;
          e_en = 3'b111;
        end else begin
          e_ss = e_seg;
          e_en = 3'(~(3'b001 << d));
        end
        check8($sformatf("ss f%0d d%0d c%0d", frame_no, d, c), ss, e_ss);
        check8($sformatf("ssen f%0d d%0d c%0d", frame_no, d, c), {5'b0, ssen}, {5'b0, e_en});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle into the DUT slot position p+1.
  task automatic wait_pos(input int p);
    int n = 0;
    do begin
      tick();
      n++;
    end while (pos != p && n < 200);
    checks++;
    if (pos != p) begin
      failures++;
      $display("FAIL wait_pos actual=%0d required=%0d", pos, p);
    end
  endtask

  task automatic wait_frame(input int f);
    int n = 0;
    do begin
      tick();
      n++;
    end while (frame_no < f && n < 200);
    checks++;
    if (frame_no < f) begin
      failures++;
      $display("FAIL wait_frame actual=%0d required=%0d", frame_no, f);
    end
  endtask

  // Drives wr_en during the cycle the DUT sits at slot position target (1..23).
  task automatic write_at(input int target, input logic [11:0] v, input logic [2:0] dp,
                          input logic [2:0] bl, output int f);
    wait_pos(target - 1);
    f        = frame_no;
    wr_en    = 1'b1;
    wr_value = v;
    wr_dp    = dp;
    wr_blank = bl;
    $display("write value=%h dp=%b blank=%b frame=%0d pos=%0d", v, dp, bl, f, target);
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    int f;
    int f2;
    int h;
    rst      = 1'b1;
    wr_en    = 1'b0;
    wr_value = 12'h000;
    wr_dp    = 3'b000;
    wr_blank = 3'b000;
    lz_en    = 1'b0;
    repeat (3) tick();

    // Reset state
    check8("reset_ss", ss, 8'hFF);
    check8("reset_ssen", {5'b0, ssen}, 8'h07);
    check8("reset_frame_done", {7'b0, frame_done}, 8'h00);
    check8("reset_pending", {7'b0, pending}, 8'h00);
    exp_q.push_back('{1, 8'hFF, 8'hFF, 8'hFF});
    exp_q.push_back('{2, 8'hFF, 8'hFF, 8'hFF});
    rst = 1'b0;
    wait_frame(2);

    // Plain write, applied at the next boundary
    write_at(5, 12'h3A8, 3'b000, 3'b000, f);
    check8("pending_set", {7'b0, pending}, 8'h01);
    exp_q.push_back('{f + 1, 8'h80, 8'h88, 8'hB0});
    wait_frame(f + 1);
    check8("pending_cleared", {7'b0, pending}, 8'h00);

    // Leading-zero suppression, then live disable
    lz_en = 1'b1;
    write_at(5, 12'h005, 3'b000, 3'b000, f);
    exp_q.push_back('{f + 1, 8'h92, 8'hFF, 8'hFF});
    exp_q.push_back('{f + 2, 8'h92, 8'hC0, 8'hC0});
    wait_frame(f + 2);
    lz_en = 1'b0;

    // Two writes in one frame: last one wins, current frame untouched
    write_at(12, 12'h111, 3'b000, 3'b000, f);
    check8("pending_first_write", {7'b0, pending}, 8'h01);
    write_at(20, 12'h222, 3'b000, 3'b000, f2);
    check8("same_frame_writes", 8'(f2 - f), 8'd0);
    exp_q.push_back('{f + 1, 8'hA4, 8'hA4, 8'hA4});
    wait_frame(f + 1);
    check8("pending_after_lww", {7'b0, pending}, 8'h00);

    // Write on the boundary cycle goes straight to active
    write_at(23, 12'hF00, 3'b100, 3'b010, f);
    check8("boundary_pending", {7'b0, pending}, 8'h00);
    check8("boundary_frame_done", {7'b0, frame_done}, 8'h01);
    exp_q.push_back('{f + 1, 8'hC0, 8'hFF, 8'h0E});
    wait_frame(f + 1);

    // Reset mid-frame at digit1 cnt5, with a competing write
    write_at(8, 12'h123, 3'b000, 3'b000, f);
    check8("pending_before_rst", {7'b0, pending}, 8'h01);
    wait_pos(12);
    rst      = 1'b1;
    wr_en    = 1'b1;
    wr_value = 12'h777;
    wr_dp    = 3'b000;
    wr_blank = 3'b000;
    $display("reset at frame=%0d pos=13 with write value=777", frame_no);
    tick();
    wr_en = 1'b0;
    check8("midrst_ss", ss, 8'hFF);
    check8("midrst_ssen", {5'b0, ssen}, 8'h07);
    check8("midrst_pending", {7'b0, pending}, 8'h00);
    check8("midrst_frame_done", {7'b0, frame_done}, 8'h00);
    h = frame_no;
    exp_q.push_back('{h + 1, 8'hFF, 8'hFF, 8'hFF});
    exp_q.push_back('{h + 2, 8'hFF, 8'hFF, 8'hFF});
    tick();
    rst = 1'b0;
    wait_frame(h + 2);
    check8("post_rst_pending", {7'b0, pending}, 8'h00);
    repeat (FRAME) tick();

    check8("scoreboard_drain", 8'(exp_q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
